instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk  in  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  in  1  one clock; reset is synchronous and active-low.
REQ-004 SHALL have port imem_req  out  1  fetch request, held until imem_ready.
REQ-005 SHALL have port imem_addr  out  16  byte address of the requested instruction.
REQ-006 SHALL have port imem_ready  in  1  imem_rdata is valid this cycle and the request completes.
REQ-007 SHALL have port imem_rdata  in  16  instruction word.
REQ-008 SHALL have port stall_i  in  1  decode cannot accept a new instruction.
REQ-009 SHALL have port redirect_valid  in  1  branch/jump taken; flush and refetch.
REQ-010 SHALL have port redirect_pc  in  16  redirect target.
REQ-011 SHALL have port if_valid  out  1  if_instr/if_pc/if_pc_inc are valid for decode.
REQ-012 SHALL have ports if_instr  out  16 (fetched word), if_pc  out  16 (its address), if_pc_inc  out  16 (if_pc+2).
REQ-013 SHALL have port halted_o  out  1  fetch stopped on HALT.

Function
REQ-014 SHALL implement FSM states FETCH, HOLD, DRAIN, HALT; imem_req=1 only in FETCH and DRAIN.
REQ-015 imem_addr SHALL stay stable while imem_req=1 and imem_ready=0; requests are never withdrawn except by reset.
REQ-016 FETCH, imem_ready=1, no redirect, output slot free (if_valid=0 or stall_i=0): next cycle if_valid=1 with captured word, pc advances by 2, stay FETCH (1-cycle latency ready->if_valid).
REQ-017 FETCH, imem_ready=1, if_valid=1 and stall_i=1: word and its pc go into a 1-entry hold register, -> HOLD, no new request.
REQ-018 HOLD: when stall_i=0, hold contents move to if_* next cycle, -> FETCH at next pc.
REQ-019 While stall_i=1 and if_valid=1, if_* SHALL hold their values unchanged.
REQ-020 redirect_valid SHALL have priority over stall_i and imem_ready: if_valid=0 and hold register cleared next cycle.
REQ-021 Redirect in FETCH with imem_ready=1, or in HOLD/HALT: data discarded, next imem_addr=redirect_pc, -> FETCH, halted_o=0.
REQ-022 Redirect in FETCH with imem_ready=0: latch redirect_pc, -> DRAIN; in DRAIN the outstanding response is discarded on imem_ready, then -> FETCH at latched target.
REQ-023 Redirect in DRAIN SHALL overwrite the latched target; redirect coincident with imem_ready in DRAIN uses the new redirect_pc.
REQ-024 PC arithmetic SHALL be modulo 2^16; 16'hFFFE+2 wraps to 16'h0000 without error.
REQ-025 if_pc_inc SHALL equal if_pc+2 (mod 2^16) whenever if_valid=1.

Reset
REQ-026 rst_n=0 at a rising edge SHALL force: state FETCH-pending, if_valid=0, if_instr=0, if_pc=0, if_pc_inc=0, halted_o=0, imem_req=0, hold cleared.
REQ-027 First cycle after rst_n returns high: imem_req=1, imem_addr=RESET_PC.
REQ-028 Reset mid-request SHALL abandon it; any imem_ready from the old request is ignored.

Configuration
REQ-029 Macro INSTR_FETCH_HALT_DETECT_EN defined: a word with opcode[15:11]=5'b00000 presented on if_* (if_valid=1, stall_i=0) -> HALT next cycle, halted_o=1, no further requests until redirect or reset.
REQ-030 Macro undefined: HALT opcode is an ordinary word, fetching continues, halted_o tied 0, HALT state absent.

Structure
REQ-031 Shared package cpu_pkg SHALL hold PC_W=16, INSTR_W=16, OPC_HALT=5'b00000, and the fetch FSM state encoding.
REQ-032 SHALL instantiate one sub-module pc_incr (16-bit +2 adder) used for next-pc and if_pc_inc.

Verification
REQ-033 Reset release, imem_ready=1 every cycle, rdata=16'h0800+addr -> if_pc=0,2,4,... consecutive cycles, if_instr matching, if_pc_inc=if_pc+2.
REQ-034 stall_i=1 for 3 cycles with if_pc=4 -> if_* frozen at pc 4, word for pc 6 held, after release pc 6 then pc 8 back-to-back, no word lost or duplicated.
REQ-035 imem_ready delayed 4 cycles at addr 8, redirect_pc=16'h0040 at cycle 2 -> addr 8 held until ready, its data dropped, next imem_addr=16'h0040, if_valid never shows pc 8.
REQ-036 Redirect to 16'hFFFE -> fetches 16'hFFFE then 16'h0000.
REQ-037 With INSTR_FETCH_HALT_DETECT_EN, word 16'h0000 at pc 10 -> halted_o=1, imem_req=0; redirect to 16'h0020 -> halted_o=0, fetch at 16'h0020; without macro fetch continues at pc 12.
REQ-038 rst_n=0 during DRAIN -> all outputs at reset values next cycle, restart at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU types: widths, HALT opcode and fetch FSM encoding.
// HALT state exists only with INSTR_FETCH_HALT_DETECT_EN defined.
package cpu_pkg;

  localparam int PC_W = 16;
  localparam int INSTR_W = 16;
  localparam logic [4:0] OPC_HALT = 5'b00000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
`ifdef INSTR_FETCH_HALT_DETECT_EN
    ,
    HALT  = 2'd3
`endif
  } fetchState_e;

endpackage

// File: rtl/pc_incr.sv
// Fixed +2 program counter incrementer, wraps modulo 2^PC_W.
module pc_incr
  import cpu_pkg::*;
(
  input  logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pcInc
);

  assign pcInc = pc + PC_W'(2);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: imem handshake, 1-entry skid, redirect drain.
// Optional HALT detection via INSTR_FETCH_HALT_DETECT_EN.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall_i,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  output logic [PC_W-1:0]    if_pc_inc,
  output logic               halted_o
);

  fetchState_e state, stateD;

  logic [PC_W-1:0]    pc, pcD, pcNext;
  logic [PC_W-1:0]    tgt, tgtD;
  logic [PC_W-1:0]    ifPc, ifPcD;
  logic [PC_W-1:0]    ifPcInc, ifPcIncD;
  logic [PC_W-1:0]    holdPc, holdPcD;
  logic [INSTR_W-1:0] ifInstr, ifInstrD;
  logic [INSTR_W-1:0] holdInstr, holdInstrD;
  logic               ifValid, ifValidD;
  logic               slotFree;
`ifdef INSTR_FETCH_HALT_DETECT_EN
  logic               haltHit;
`endif

  pc_incr uPcIncr (
    .pc    (pc),
    .pcInc (pcNext)
  );

  assign slotFree = !ifValid || !stall_i;
`ifdef INSTR_FETCH_HALT_DETECT_EN
  assign haltHit = ifValid && !stall_i &&
                   (ifInstr[15:11] == OPC_HALT);
`endif

  always_comb begin
    stateD     = state;
    pcD        = pc;
    tgtD       = tgt;
    ifValidD   = ifValid;
    ifInstrD   = ifInstr;
    ifPcD      = ifPc;
    ifPcIncD   = ifPcInc;
    holdInstrD = holdInstr;
    holdPcD    = holdPc;
    if (redirect_valid) begin
      ifValidD   = 1'b0;
      holdInstrD = '0;
      holdPcD    = '0;
      // An unanswered request must complete before refetching
      if (state == FETCH && !imem_ready) begin
        stateD = DRAIN;
        tgtD   = redirect_pc;
      end else if (state == DRAIN && !imem_ready) begin
        tgtD = redirect_pc;
      end else begin
        stateD = FETCH;
        pcD    = redirect_pc;
      end
    end else begin
      unique case (state)
        FETCH: begin
`ifdef INSTR_FETCH_HALT_DETECT_EN
          if (haltHit) begin
            stateD   = HALT;
            ifValidD = 1'b0;
          end else
`endif
          if (imem_ready && slotFree) begin
            ifValidD = 1'b1;
            ifInstrD = imem_rdata;
            ifPcD    = pc;
            ifPcIncD = pcNext;
            pcD      = pcNext;
          end else if (imem_ready) begin
            holdInstrD = imem_rdata;
            holdPcD    = pc;
            pcD        = pcNext;
            stateD     = HOLD;
          end else if (slotFree) begin
            ifValidD = 1'b0;
          end
        end
        HOLD: begin
`ifdef INSTR_FETCH_HALT_DETECT_EN
          if (haltHit) begin
            stateD     = HALT;
            ifValidD   = 1'b0;
            holdInstrD = '0;
            holdPcD    = '0;
          end else
`endif
          if (!stall_i) begin
            // pc already sits one word past holdPc
            ifValidD   = 1'b1;
            ifInstrD   = holdInstr;
            ifPcD      = holdPc;
            ifPcIncD   = pc;
            holdInstrD = '0;
            holdPcD    = '0;
            stateD     = FETCH;
          end
        end
        DRAIN: begin
          if (imem_ready) begin
            stateD = FETCH;
            pcD    = tgt;
          end
        end
`ifdef INSTR_FETCH_HALT_DETECT_EN
        HALT: begin
          ifValidD = 1'b0;
        end
`endif
        default: begin
          stateD = FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      tgt       <= '0;
      ifValid   <= 1'b0;
      ifInstr   <= '0;
      ifPc      <= '0;
      ifPcInc   <= '0;
      holdInstr <= '0;
      holdPc    <= '0;
    end else begin
      state     <= stateD;
      pc        <= pcD;
      tgt       <= tgtD;
      ifValid   <= ifValidD;
      ifInstr   <= ifInstrD;
      ifPc      <= ifPcD;
      ifPcInc   <= ifPcIncD;
      holdInstr <= holdInstrD;
      holdPc    <= holdPcD;
    end
  end

  // No request while reset is asserted
  assign imem_req  = rst_n && (state == FETCH || state == DRAIN);
  assign imem_addr = pc;
  assign if_valid  = ifValid;
  assign if_instr  = ifInstr;
  assign if_pc     = ifPc;
  assign if_pc_inc = ifPcInc;

`ifdef INSTR_FETCH_HALT_DETECT_EN
  assign halted_o = (state == HALT);
`else
  assign halted_o = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch.
// Honors INSTR_FETCH_HALT_DETECT_EN for the HALT scenario.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_rdata;
  logic        stall_i;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic [15:0] if_pc_inc;
  logic        halted_o;

  logic        haltEn;
  int          checks;
  int          errors;

  instr_fetch #(.RESET_PC(16'h0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .stall_i        (stall_i),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_inc      (if_pc_inc),
    .halted_o       (halted_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] memWord(input logic [15:0] a,
                                          input logic hEn);
    if (hEn && a == 16'h000A) return 16'h0000;
    if (a < 16'h1000) return 16'h0800 + a;
    return a ^ 16'h5A5A;
  endfunction

  assign imem_rdata = memWord(imem_addr, haltEn);

  wire [48:0] ifBus = {if_valid, if_pc, if_instr, if_pc_inc};

  task automatic test_reset;
    rst_n = 1'b0;
    imem_ready = 1'b0;
    stall_i = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (ifBus !== 49'd0 || imem_req !== 1'b0 || halted_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_state bus=%h req=%b halt=%b want 0", ifBus,
               imem_req, halted_o);
    end
    rst_n = 1'b1;
    imem_ready = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      errors++;
      $display("FAIL reset_release req=%b addr=%h want 1 0000",
               imem_req, imem_addr);
    end
  endtask

  task automatic test_stream;
    for (int k = 0; k < 3; k++) begin
      logic [15:0] p;
      p = 16'(2 * k);
      @(negedge clk);
      checks++;
      if (ifBus !== {1'b1, p, 16'h0800 + p, p + 16'd2}) begin
        errors++;
        $display("FAIL stream k=%0d got %h want %h", k, ifBus,
                 {1'b1, p, 16'h0800 + p, p + 16'd2});
      end
    end
  endtask

  task automatic test_stall;
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (ifBus !== {1'b1, 16'd4, 16'h0804, 16'd6} || imem_req !== 1'b0) begin
        errors++;
        $display("FAIL stall_freeze i=%0d got %h req=%b", i, ifBus, imem_req);
      end
    end
    stall_i = 1'b0;
    @(negedge clk);
    checks++;
    if (ifBus !== {1'b1, 16'd6, 16'h0806, 16'd8}) begin
      errors++;
      $display("FAIL stall_release_pc6 got %h", ifBus);
    end
    @(negedge clk);
    checks++;
    if (ifBus !== {1'b1, 16'd8, 16'h0808, 16'd10}) begin
      errors++;
      $display("FAIL back_to_back_pc8 got %h", ifBus);
    end
  endtask

  task automatic test_redirect_drain;
    redirect_valid = 1'b1;
    redirect_pc = 16'h0008;
    @(negedge clk);
    redirect_valid = 1'b0;
    imem_ready = 1'b0;
    checks++;
    if (if_valid !== 1'b0 || imem_addr !== 16'h0008) begin
      errors++;
      $display("FAIL redir_to_8 valid=%b addr=%h", if_valid, imem_addr);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 16'h0008 || if_valid !== 1'b0) begin
        errors++;
        $display("FAIL drain_hold i=%0d req=%b addr=%h valid=%b", i,
                 imem_req, imem_addr, if_valid);
      end
      if (i == 0) begin
        redirect_valid = 1'b1;
        redirect_pc = 16'h0040;
      end else begin
        redirect_valid = 1'b0;
      end
      if (i == 3) imem_ready = 1'b1;
    end
    @(negedge clk);
    checks++;
    if (imem_addr !== 16'h0040 || if_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_target addr=%h valid=%b want 0040 0",
               imem_addr, if_valid);
    end
    @(negedge clk);
    checks++;
    if (ifBus !== {1'b1, 16'h0040, 16'h0840, 16'h0042}) begin
      errors++;
      $display("FAIL drain_first_word got %h", ifBus);
    end
  endtask

  task automatic test_wrap;
    redirect_valid = 1'b1;
    redirect_pc = 16'hFFFE;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++;
    if (imem_addr !== 16'hFFFE || if_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_addr addr=%h valid=%b", imem_addr, if_valid);
    end
    @(negedge clk);
    checks++;
    if (ifBus !== {1'b1, 16'hFFFE, 16'hA5A4, 16'h0000}) begin
      errors++;
      $display("FAIL wrap_fffe got %h", ifBus);
    end
    @(negedge clk);
    checks++;
    if (ifBus !== {1'b1, 16'h0000, 16'h0800, 16'h0002}) begin
      errors++;
      $display("FAIL wrap_0000 got %h", ifBus);
    end
  endtask

  task automatic test_halt;
    haltEn = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 16'h000A;
    @(negedge clk);
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (ifBus !== {1'b1, 16'h000A, 16'h0000, 16'h000C}) begin
      errors++;
      $display("FAIL halt_word got %h", ifBus);
    end
    @(negedge clk);
`ifdef INSTR_FETCH_HALT_DETECT_EN
    checks++;
    if (halted_o !== 1'b1 || imem_req !== 1'b0 || if_valid !== 1'b0) begin
      errors++;
      $display("FAIL halted halt=%b req=%b valid=%b want 1 0 0",
               halted_o, imem_req, if_valid);
    end
    redirect_valid = 1'b1;
    redirect_pc = 16'h0020;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++;
    if (halted_o !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0020) begin
      errors++;
      $display("FAIL halt_exit halt=%b req=%b addr=%h",
               halted_o, imem_req, imem_addr);
    end
`else
    checks++;
    if (ifBus !== {1'b1, 16'h000C, 16'h080C, 16'h000E} || halted_o !== 1'b0) begin
      errors++;
      $display("FAIL no_halt got %h halt=%b", ifBus, halted_o);
    end
`endif
    haltEn = 1'b0;
  endtask

  task automatic test_reset_in_drain;
    imem_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 16'h0030;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || if_valid !== 1'b0) begin
      errors++;
      $display("FAIL enter_drain req=%b valid=%b", imem_req, if_valid);
    end
    rst_n = 1'b0;
    imem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (ifBus !== 49'd0 || imem_req !== 1'b0 || halted_o !== 1'b0) begin
      errors++;
      $display("FAIL drain_reset bus=%h req=%b halt=%b", ifBus,
               imem_req, halted_o);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      errors++;
      $display("FAIL drain_restart req=%b addr=%h", imem_req, imem_addr);
    end
    @(negedge clk);
    checks++;
    if (ifBus !== {1'b1, 16'h0000, 16'h0800, 16'h0002}) begin
      errors++;
      $display("FAIL restart_word got %h", ifBus);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    haltEn = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_drain();
    test_wrap();
    test_halt();
    test_reset_in_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
